// File: rtl/rr_mux.sv
// rr_mux: N-input, WIDTH-bit round-robin multiplexer with valid/ready
// handshakes on every input channel and a registered output stage.
//
// Build option:
//   RR_MUX_FIXED_PRI_EN  - when defined, arbitration is fixed priority
//                          (lowest index wins, no rotating pointer).
//                          When undefined (default), round-robin
//                          arbitration with a rotating priority pointer.
//
// Handshake summary:
//   - An input word is taken on an edge where in_valid[i] && in_ready[i].
//   - The output stage reloads whenever it is empty or draining this
//     cycle, so a steady out_ready gives one word per cycle with no bubble.
//   - in_ready is a function of in_valid, out_ready and the internal
//     state only; it never looks at in_data.
module rr_mux #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    localparam int SELW = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SELW-1:0]      out_sel
);

    // ------------------------------------------------------------------
    // Output stage state
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] out_data_reg;
    logic [SELW-1:0]  out_sel_reg;
    logic             out_valid_reg;

    // ------------------------------------------------------------------
    // Arbitration signals
    // ------------------------------------------------------------------
    logic [N-1:0]     grant;        // one-hot winner, or zero if no request
    logic [SELW-1:0]  grant_idx;    // binary index of the winner
    logic             grant_any;    // some channel is requesting
    logic             load;         // output stage can accept a new word

    // Per-channel view of the packed input bus
    logic [WIDTH-1:0] chan_data [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_unpack
            assign chan_data[gi] = in_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // The stage reloads when empty or when its current word leaves now
    assign load = !out_valid_reg || out_ready;

`ifdef RR_MUX_FIXED_PRI_EN

    // Fixed priority: scan from channel 0 upwards, first request wins
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!grant_any && in_valid[k]) begin
                grant[k]  = 1'b1;
                grant_idx = SELW'(k);
                grant_any = 1'b1;
            end
        end
    end

`else

    // Priority pointer: the channel that is searched first next time
    logic [SELW-1:0] ptr_reg;
    logic [SELW-1:0] ptr_next;

    // Round-robin: scan ptr, ptr+1, ... (mod N); first request wins
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!grant_any && in_valid[(int'(ptr_reg) + k) % N]) begin
                grant[(int'(ptr_reg) + k) % N] = 1'b1;
                grant_idx = SELW'((int'(ptr_reg) + k) % N);
                grant_any = 1'b1;
            end
        end
    end

    // Pointer moves to the channel after the winner, wrapping at N-1.
    // N need not be a power of two, so the wrap is explicit.
    always_comb begin
        ptr_next = ptr_reg;
        if (load && grant_any) begin
            if (grant_idx == SELW'(N - 1)) begin
                ptr_next = '0;
            end else begin
                ptr_next = grant_idx + SELW'(1);
            end
        end
    end

    // Pointer register; only advances on an actual input transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

`endif

    // Grant is only offered while the stage can take it and not in reset
    assign in_ready = (load && !rst) ? grant : '0;

    // Output stage: capture the winner, drain to empty, or hold under backpressure
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_reg  <= '0;
            out_sel_reg   <= '0;
            out_valid_reg <= 1'b0;
        end else if (load) begin
            if (grant_any) begin
                out_data_reg  <= chan_data[grant_idx];
                out_sel_reg   <= grant_idx;
                out_valid_reg <= 1'b1;
            end else begin
                // Nothing to load: become empty, keep last word/index
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_data  = out_data_reg;
    assign out_sel   = out_sel_reg;
    assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_rr_mux.sv
// tb_rr_mux: directed, table-driven bench for rr_mux (N=4, WIDTH=32).
// Each table row drives in_valid/out_ready (and channel 2's word) before a
// rising edge, checks in_ready just before the edge and the output stage
// just after it. Reset and mid-cycle reset are hand-written sequences.
module tb_rr_mux;

    localparam int WIDTH = 32;
    localparam int N     = 4;

    localparam logic [31:0] D0 = 32'hAAAAAAAA;
    localparam logic [31:0] D1 = 32'h55555555;
    localparam logic [31:0] D2 = 32'hFFFFFFFF;
    localparam logic [31:0] D3 = 32'hDDDDDDDD;
    localparam logic [31:0] DB = 32'hA5A5A5A5;
    localparam logic [31:0] DX = 32'h12345678;

    logic               clk;
    logic               rst;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_valid;
    logic               out_ready;
    logic [1:0]         out_sel;

    int n_checks;
    int n_fail;

    typedef struct {
        logic [3:0]  valid;
        logic        ordy;
        logic [31:0] ch2;
        logic [3:0]  exp_rdy;
        logic        exp_ov;
        logic [1:0]  exp_sel;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[$];

    rr_mux #(.WIDTH(WIDTH), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sel   (out_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] v, input logic r, input logic [31:0] c2,
                       input logic [3:0] er, input logic eov, input logic [1:0] es,
                       input logic [31:0] ed);
        vec_t t;
        t.valid = v; t.ordy = r; t.ch2 = c2;
        t.exp_rdy = er; t.exp_ov = eov; t.exp_sel = es; t.exp_data = ed;
        vecs.push_back(t);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        in_data   = {D3, D2, D1, D0};

`ifdef RR_MUX_FIXED_PRI_EN
        // Fixed priority: channel 0 always wins when valid
        add(4'b1111, 1'b1, D2, 4'b0001, 1'b1, 2'd0, D0);
        add(4'b1111, 1'b1, D2, 4'b0001, 1'b1, 2'd0, D0);
        add(4'b1111, 1'b1, D2, 4'b0001, 1'b1, 2'd0, D0);
        add(4'b1110, 1'b1, D2, 4'b0010, 1'b1, 2'd1, D1);
        add(4'b1000, 1'b1, D2, 4'b1000, 1'b1, 2'd3, D3);
        add(4'b1111, 1'b0, D2, 4'b0000, 1'b1, 2'd3, D3);
        add(4'b0000, 1'b1, D2, 4'b0000, 1'b0, 2'd3, D3);
`else
        // Round-robin over all four channels
        add(4'b1111, 1'b1, D2, 4'b0001, 1'b1, 2'd0, D0);
        add(4'b1111, 1'b1, D2, 4'b0010, 1'b1, 2'd1, D1);
        add(4'b1111, 1'b1, D2, 4'b0100, 1'b1, 2'd2, D2);
        add(4'b1111, 1'b1, D2, 4'b1000, 1'b1, 2'd3, D3);
        add(4'b1111, 1'b1, D2, 4'b0001, 1'b1, 2'd0, D0);
        // Sparse requests with wrap (ptr=1 here)
        add(4'b1001, 1'b1, D2, 4'b1000, 1'b1, 2'd3, D3);
        add(4'b1001, 1'b1, D2, 4'b0001, 1'b1, 2'd0, D0);
        add(4'b1001, 1'b1, D2, 4'b1000, 1'b1, 2'd3, D3);
        add(4'b1001, 1'b1, D2, 4'b0001, 1'b1, 2'd0, D0);
        // Backpressure on a word from channel 2; channel 2 changes its word meanwhile
        add(4'b0100, 1'b1, DB, 4'b0100, 1'b1, 2'd2, DB);
        add(4'b0100, 1'b0, DX, 4'b0000, 1'b1, 2'd2, DB);
        add(4'b0100, 1'b0, DX, 4'b0000, 1'b1, 2'd2, DB);
        add(4'b0100, 1'b0, DX, 4'b0000, 1'b1, 2'd2, DB);
        add(4'b0100, 1'b0, DX, 4'b0000, 1'b1, 2'd2, DB);
        add(4'b0100, 1'b0, DX, 4'b0000, 1'b1, 2'd2, DB);
        // Release: next grant in the same cycle (ptr=3, channel 0 wins)
        add(4'b0001, 1'b1, D2, 4'b0001, 1'b1, 2'd0, D0);
        // Idle: drains to empty, last word/index held
        add(4'b0000, 1'b1, D2, 4'b0000, 1'b0, 2'd0, D0);
        add(4'b0000, 1'b1, D2, 4'b0000, 1'b0, 2'd0, D0);
        // Pointer survived idle (ptr=1)
        add(4'b1111, 1'b1, D2, 4'b0010, 1'b1, 2'd1, D1);
        add(4'b1111, 1'b0, D2, 4'b0000, 1'b1, 2'd1, D1);
        // Channels drop before being granted: nothing lost, stage drains
        add(4'b0000, 1'b0, D2, 4'b0000, 1'b1, 2'd1, D1);
        add(4'b0000, 1'b1, D2, 4'b0000, 1'b0, 2'd1, D1);
        add(4'b1111, 1'b1, D2, 4'b0100, 1'b1, 2'd2, D2);
`endif

        // Reset held for two edges with every channel requesting
        repeat (2) begin
            @(posedge clk);
            #1;
            check("reset_out_valid", 32'(out_valid), 32'd0);
            check("reset_in_ready", 32'(in_ready), 32'd0);
        end
        check("reset_out_data", out_data, 32'd0);
        check("reset_out_sel", 32'(out_sel), 32'd0);
        $display("reset: out_valid=%0b out_sel=%0d out_data=%h in_ready=%b",
                 out_valid, out_sel, out_data, in_ready);

        @(negedge clk);
        rst = 1'b0;

        // Apply the table
        for (int i = 0; i < vecs.size(); i++) begin
            in_valid  = vecs[i].valid;
            out_ready = vecs[i].ordy;
            in_data   = {D3, vecs[i].ch2, D1, D0};
            #1;
            check($sformatf("row%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
            @(posedge clk);
            #1;
            check($sformatf("row%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
            if (vecs[i].exp_ov) begin
                check($sformatf("row%0d_out_sel", i), 32'(out_sel), 32'(vecs[i].exp_sel));
            end
            check($sformatf("row%0d_out_data", i), out_data, vecs[i].exp_data);
            $display("row %0d: valid=%b ordy=%0b in_ready=%b -> out_valid=%0b out_sel=%0d out_data=%h",
                     i, vecs[i].valid, vecs[i].ordy, vecs[i].exp_rdy, out_valid, out_sel, out_data);
            @(negedge clk);
        end

        // Mid-cycle asynchronous reset while a word is held
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        in_data   = {D3, D2, D1, D0};
        @(posedge clk);
        #1;
        check("midrst_pre_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_data", out_data, 32'd0);
        check("midrst_out_sel", 32'(out_sel), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        $display("midrst: out_valid=%0b out_sel=%0d out_data=%h", out_valid, out_sel, out_data);
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        #1;
        check("postrst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        check("postrst_sel0", 32'(out_sel), 32'd0);
        check("postrst_data0", out_data, D0);
        $display("postrst grant 0: out_sel=%0d out_data=%h", out_sel, out_data);
        @(posedge clk);
        #1;
`ifdef RR_MUX_FIXED_PRI_EN
        check("postrst_sel1", 32'(out_sel), 32'd0);
        check("postrst_data1", out_data, D0);
`else
        check("postrst_sel1", 32'(out_sel), 32'd1);
        check("postrst_data1", out_data, D1);
`endif
        $display("postrst grant 1: out_sel=%0d out_data=%h", out_sel, out_data);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
